// File: rtl/systolic_result_checker.sv
// Self-test result checker for one systolic array output row: per-column compare,
// column masking, sticky fault map, saturating failing-vector count and session FSM.
module systolic_result_checker #(
  parameter int SYSTOLIC_SIZE     = 8,
  parameter int WEIGHT_WIDTH      = 8,
  parameter int ACTIVATION_WIDTH  = 8,
  parameter int PARTIAL_SUM_WIDTH = WEIGHT_WIDTH + ACTIVATION_WIDTH + $clog2(SYSTOLIC_SIZE),
  parameter int FAIL_CNT_WIDTH    = 8
) (
  input  logic                                       clk,
  input  logic                                       rst,
  input  logic                                       start,
  input  logic                                       cmp_valid,
  input  logic                                       test_done,
  input  logic [SYSTOLIC_SIZE-1:0]                   column_mask,
  input  logic [PARTIAL_SUM_WIDTH*SYSTOLIC_SIZE-1:0] correct_answer_flat,
  input  logic [PARTIAL_SUM_WIDTH*SYSTOLIC_SIZE-1:0] partial_sum_flat,
  output logic [SYSTOLIC_SIZE-1:0]                   compared_results,
  output logic                                       result_valid,
  output logic [SYSTOLIC_SIZE-1:0]                   fault_map,
  output logic [FAIL_CNT_WIDTH-1:0]                  fail_count,
  output logic                                       busy,
  output logic                                       done,
  output logic                                       all_pass
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_RUN    = 2'd1;
  localparam logic [1:0] ST_REPORT = 2'd2;

  logic [1:0]               state;
  logic [1:0]               state_nxt;
  logic [SYSTOLIC_SIZE-1:0] mismatch;
  logic                     any_mismatch;
  logic                     count_saturated;

  // Exact full-width compare; a masked column can never report a mismatch.
  for (genvar i = 0; i < SYSTOLIC_SIZE; i++) begin : g_col
    assign mismatch[i] = (correct_answer_flat[i*PARTIAL_SUM_WIDTH +: PARTIAL_SUM_WIDTH] !=
                          partial_sum_flat[i*PARTIAL_SUM_WIDTH +: PARTIAL_SUM_WIDTH]) &
                         ~column_mask[i];
  end

  assign any_mismatch    = |mismatch;
  assign count_saturated = &fail_count;

  always_comb begin
    // NOTE: default assignment first so no path leaves state_nxt unassigned (no latch).
    state_nxt = state;
    case (state)
      ST_IDLE:   if (start) state_nxt = ST_RUN;
      ST_RUN:    if (test_done) state_nxt = ST_REPORT;
      ST_REPORT: state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      state            <= ST_IDLE;
      compared_results <= '0;
      result_valid     <= 1'b0;
      fault_map        <= '0;
      fail_count       <= '0;
    end else begin
      state        <= state_nxt;
      result_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            compared_results <= '0;
            fault_map        <= '0;
            fail_count       <= '0;
          end
        end
        ST_RUN: begin
          // A vector arriving together with test_done is still accumulated.
          if (cmp_valid) begin
            compared_results <= mismatch;
            result_valid     <= 1'b1;
            fault_map        <= fault_map | mismatch;
            if (any_mismatch && !count_saturated) fail_count <= fail_count + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy     = (state == ST_RUN);
  assign done     = (state == ST_REPORT);
  assign all_pass = done && (fault_map == '0);

endmodule

// File: tb/tb_systolic_result_checker.sv
// Self-checking bench for systolic_result_checker: directed scenarios plus random
// sessions against a vector-level reference model; a second instance checks saturation.
module tb_systolic_result_checker;

  localparam int N   = 8;
  localparam int PSW = 8 + 8 + $clog2(N);

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic             cmp_valid = 1'b0;
  logic             test_done = 1'b0;
  logic [N-1:0]     column_mask = '0;
  logic [PSW*N-1:0] correct_answer_flat = '0;
  logic [PSW*N-1:0] partial_sum_flat = '0;

  logic [N-1:0] compared_results, fault_map, compared_results2, fault_map2;
  logic [7:0]   fail_count;
  logic [1:0]   fail_count2;
  logic         result_valid, busy, done, all_pass;
  logic         result_valid2, busy2, done2, all_pass2;

  int checks = 0;
  int errors = 0;

  // Reference model state: per-session vector-level results.
  logic [N-1:0] m_fault;
  int           m_fail;

  systolic_result_checker u_dut (
    .clk(clk), .rst(rst), .start(start), .cmp_valid(cmp_valid), .test_done(test_done),
    .column_mask(column_mask), .correct_answer_flat(correct_answer_flat),
    .partial_sum_flat(partial_sum_flat), .compared_results(compared_results),
    .result_valid(result_valid), .fault_map(fault_map), .fail_count(fail_count),
    .busy(busy), .done(done), .all_pass(all_pass)
  );

  systolic_result_checker #(.FAIL_CNT_WIDTH(2)) u_dut2 (
    .clk(clk), .rst(rst), .start(start), .cmp_valid(cmp_valid), .test_done(test_done),
    .column_mask(column_mask), .correct_answer_flat(correct_answer_flat),
    .partial_sum_flat(partial_sum_flat), .compared_results(compared_results2),
    .result_valid(result_valid2), .fault_map(fault_map2), .fail_count(fail_count2),
    .busy(busy2), .done(done2), .all_pass(all_pass2)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int exp_cnt(input int width);
    int lim = (1 << width) - 1;
    return (m_fail > lim) ? lim : m_fail;
  endfunction

  task automatic chk_accum(input string tag);
    chk({tag, "_fault"}, 32'(fault_map), 32'(m_fault));
    chk({tag, "_fault2"}, 32'(fault_map2), 32'(m_fault));
    chk({tag, "_cnt"}, 32'(fail_count), 32'(exp_cnt(8)));
    chk({tag, "_cnt2"}, 32'(fail_count2), 32'(exp_cnt(2)));
  endtask

  task automatic start_session();
    start = 1'b1;
    step();
    start = 1'b0;
    m_fault = '0;
    m_fail  = 0;
    chk("start_busy", 32'(busy), 32'd1);
    chk("start_rv", 32'(result_valid), 32'd0);
    chk("start_cmp", 32'(compared_results), 32'd0);
    chk_accum("start");
  endtask

  // One vector; err_cols chooses columns whose actual sum is corrupted.
  task automatic send_vec(input logic [N-1:0] mask, input logic [N-1:0] err_cols, input bit last);
    logic [PSW-1:0] e [N];
    logic [PSW-1:0] a [N];
    logic [N-1:0]   mm;
    mm = '0;
    for (int i = 0; i < N; i++) begin
      e[i] = PSW'($urandom);
      a[i] = e[i];
      if (err_cols[i]) a[i] = e[i] ^ PSW'($urandom_range(1, (1 << PSW) - 1));
      correct_answer_flat[i*PSW +: PSW] = e[i];
      partial_sum_flat[i*PSW +: PSW]    = a[i];
      if (e[i] != a[i] && !mask[i]) mm[i] = 1'b1;
    end
    column_mask = mask;
    cmp_valid   = 1'b1;
    test_done   = last;
    step();
    cmp_valid = 1'b0;
    test_done = 1'b0;
    m_fault |= mm;
    if (mm != '0) m_fail++;
    chk("vec_rv", 32'(result_valid), 32'd1);
    chk("vec_cmp", 32'(compared_results), 32'(mm));
    chk_accum("vec");
    if (last) begin
      chk("vec_done", 32'(done), 32'd1);
      chk("vec_pass", 32'(all_pass), 32'(m_fault == '0));
      chk("vec_busy", 32'(busy), 32'd0);
    end else begin
      chk("vec_busy", 32'(busy), 32'd1);
      chk("vec_done", 32'(done), 32'd0);
    end
  endtask

  task automatic end_session();
    test_done = 1'b1;
    step();
    test_done = 1'b0;
    chk("end_done", 32'(done), 32'd1);
    chk("end_pass", 32'(all_pass), 32'(m_fault == '0));
    chk("end_rv", 32'(result_valid), 32'd0);
    chk_accum("end");
  endtask

  task automatic after_report();
    step();
    chk("post_done", 32'(done), 32'd0);
    chk("post_pass", 32'(all_pass), 32'd0);
    chk("post_busy", 32'(busy), 32'd0);
    chk_accum("post");
  endtask

  initial begin
    // Reset for two cycles.
    step();
    step();
    rst = 1'b0;
    chk("rst_cmp", 32'(compared_results), 32'd0);
    chk("rst_rv", 32'(result_valid), 32'd0);
    chk("rst_fault", 32'(fault_map), 32'd0);
    chk("rst_cnt", 32'(fail_count), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_pass", 32'(all_pass), 32'd0);

    // All-equal vectors: clean session.
    start_session();
    for (int v = 0; v < 4; v++) send_vec(8'h00, 8'h00, 1'b0);
    end_session();
    chk("clean_pass", 32'(all_pass), 32'd1);
    after_report();

    // Column 3 corrupted on vector 2 only.
    start_session();
    for (int v = 0; v < 4; v++) begin
      send_vec(8'h00, (v == 1) ? 8'h08 : 8'h00, 1'b0);
      if (v == 1) chk("c3_cmp", 32'(compared_results), 32'h08);
    end
    end_session();
    chk("c3_fault", 32'(fault_map), 32'h08);
    chk("c3_cnt", 32'(fail_count), 32'd1);
    chk("c3_pass", 32'(all_pass), 32'd0);
    after_report();

    // Same error with column 3 masked.
    start_session();
    for (int v = 0; v < 4; v++) send_vec(8'h08, (v == 1) ? 8'h08 : 8'h00, 1'b0);
    end_session();
    chk("mask_fault", 32'(fault_map), 32'h00);
    chk("mask_pass", 32'(all_pass), 32'd1);
    after_report();

    // Saturation of the 2-bit counter; last failing vector carries test_done.
    start_session();
    for (int v = 0; v < 4; v++) send_vec(8'h00, 8'h01, 1'b0);
    send_vec(8'h00, 8'h80, 1'b1);
    chk("sat_cnt2", 32'(fail_count2), 32'd3);
    chk("sat_cnt8", 32'(fail_count), 32'd5);
    chk("sat_fault", 32'(fault_map), 32'h81);
    after_report();

    // Mid-session mask change only affects later vectors.
    start_session();
    send_vec(8'h00, 8'h10, 1'b0);
    send_vec(8'h10, 8'h10, 1'b0);
    chk("maskchg_cmp", 32'(compared_results), 32'h00);
    end_session();
    after_report();

    // start during RUN is ignored, accumulated state is kept.
    start_session();
    send_vec(8'h00, 8'h24, 1'b0);
    start = 1'b1;
    step();
    start = 1'b0;
    chk("restart_busy", 32'(busy), 32'd1);
    chk_accum("restart");

    // Reset mid-RUN discards everything.
    send_vec(8'h00, 8'h02, 1'b0);
    rst       = 1'b1;
    cmp_valid = 1'b1;
    step();
    rst       = 1'b0;
    cmp_valid = 1'b0;
    m_fault   = '0;
    m_fail    = 0;
    chk("mrst_cmp", 32'(compared_results), 32'd0);
    chk("mrst_rv", 32'(result_valid), 32'd0);
    chk("mrst_busy", 32'(busy), 32'd0);
    chk("mrst_done", 32'(done), 32'd0);
    chk_accum("mrst");

    // cmp_valid / test_done in IDLE are ignored.
    cmp_valid = 1'b1;
    test_done = 1'b1;
    step();
    step();
    cmp_valid = 1'b0;
    test_done = 1'b0;
    chk("idle_rv", 32'(result_valid), 32'd0);
    chk("idle_busy", 32'(busy), 32'd0);
    chk("idle_done", 32'(done), 32'd0);
    chk_accum("idle");

    // Random sessions.
    for (int s = 0; s < 8; s++) begin
      int          nv;
      bit          joint;
      logic [N-1:0] mask;
      mask  = N'($urandom) & N'($urandom);
      nv    = $urandom_range(2, 8);
      joint = 1'($urandom);
      start_session();
      for (int v = 0; v < nv; v++) begin
        send_vec(mask, ($urandom_range(0, 2) == 0) ? N'($urandom) : N'(0), joint && (v == nv - 1));
        if ($urandom_range(0, 3) == 0 && !(joint && v == nv - 1)) begin
          step();
          chk("gap_rv", 32'(result_valid), 32'd0);
          chk_accum("gap");
        end
      end
      if (!joint) end_session();
      after_report();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
